// File: rtl/calc_arbiter.sv
// Two-client round-robin sequencer in front of a shared calculator datapath.
// Optional CALC_STATS_EN adds saturating operation/timeout counters.
module calc_arbiter #(
  parameter int width   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               req0_i,
  input  logic [width-1:0]   a0_i,
  input  logic [width-1:0]   b0_i,
  input  logic [1:0]         fct0_i,
  output logic               ack0_o,
  output logic [2*width-1:0] res0_o,
  output logic [2*width-1:0] rem0_o,
  output logic               valid0_o,
  input  logic               req1_i,
  input  logic [width-1:0]   a1_i,
  input  logic [width-1:0]   b1_i,
  input  logic [1:0]         fct1_i,
  output logic               ack1_o,
  output logic [2*width-1:0] res1_o,
  output logic [2*width-1:0] rem1_o,
  output logic               valid1_o,
  output logic               calc_start_o,
  output logic [width-1:0]   calc_a_o,
  output logic [width-1:0]   calc_b_o,
  output logic [1:0]         calc_fct_o,
  input  logic [2*width-1:0] calc_res_i,
  input  logic [2*width-1:0] calc_rem_i,
  input  logic               calc_done_i,
  output logic               busy_o,
`ifdef CALC_STATS_EN
  output logic [15:0]        ops_cnt_o,
  output logic [15:0]        tmo_cnt_o,
`endif
  output logic               timeout_o
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RELEASE} state_t;

  state_t             state_q, state_d;
  logic               ptr_q, ptr_d;
  logic               gnt_q, gnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         ack_q, ack_d;
  logic [1:0]         valid_q, valid_d;
  logic               start_q, start_d;
  logic               timeout_q, timeout_d;
  logic               busy_q, busy_d;
  logic [width-1:0]   calc_a_q, calc_a_d, calc_b_q, calc_b_d;
  logic [1:0]         calc_fct_q, calc_fct_d;
  logic [2*width-1:0] res0_q, res0_d, rem0_q, rem0_d;
  logic [2*width-1:0] res1_q, res1_d, rem1_q, rem1_d;

  logic any_req;
  logic gnt_sel;

  // On a tie the client that was not served last wins.
  assign any_req = req0_i | req1_i;
  assign gnt_sel = (req0_i & req1_i) ? ~ptr_q : req1_i;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clock_i) begin
    if (!reset_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (any_req) state_d = S_START;
      S_START:   state_d = S_WAIT;
      S_WAIT:    if (calc_done_i || cnt_q == CNT_LAST) state_d = S_RELEASE;
      S_RELEASE: if (!calc_done_i) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case statement can infer a latch.
  always_comb begin
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    cnt_d      = cnt_q;
    ack_d      = 2'b00;
    valid_d    = 2'b00;
    start_d    = 1'b0;
    timeout_d  = 1'b0;
    busy_d     = (state_d != S_IDLE);
    calc_a_d   = calc_a_q;
    calc_b_d   = calc_b_q;
    calc_fct_d = calc_fct_q;
    res0_d     = res0_q;
    rem0_d     = rem0_q;
    res1_d     = res1_q;
    rem1_d     = rem1_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          gnt_d          = gnt_sel;
          ptr_d          = gnt_sel;
          ack_d[gnt_sel] = 1'b1;
          start_d        = 1'b1;
          calc_a_d       = gnt_sel ? a1_i   : a0_i;
          calc_b_d       = gnt_sel ? b1_i   : b0_i;
          calc_fct_d     = gnt_sel ? fct1_i : fct0_i;
        end
      end
      S_START: cnt_d = '0;
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (calc_done_i || cnt_q == CNT_LAST) begin
          valid_d[gnt_q] = 1'b1;
          timeout_d      = !calc_done_i;
          if (gnt_q) begin
            res1_d = calc_done_i ? calc_res_i : '0;
            rem1_d = calc_done_i ? calc_rem_i : '0;
          end else begin
            res0_d = calc_done_i ? calc_res_i : '0;
            rem0_d = calc_done_i ? calc_rem_i : '0;
          end
        end
      end
      default: ;
    endcase
  end

  // NOTE: the datapath registers are reset too, because results and latched
  // operands must read as zero after reset, not merely be flagged invalid.
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      ptr_q      <= 1'b1;
      gnt_q      <= 1'b0;
      cnt_q      <= '0;
      ack_q      <= 2'b00;
      valid_q    <= 2'b00;
      start_q    <= 1'b0;
      timeout_q  <= 1'b0;
      busy_q     <= 1'b0;
      calc_a_q   <= '0;
      calc_b_q   <= '0;
      calc_fct_q <= '0;
      res0_q     <= '0;
      rem0_q     <= '0;
      res1_q     <= '0;
      rem1_q     <= '0;
    end else begin
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      valid_q    <= valid_d;
      start_q    <= start_d;
      timeout_q  <= timeout_d;
      busy_q     <= busy_d;
      calc_a_q   <= calc_a_d;
      calc_b_q   <= calc_b_d;
      calc_fct_q <= calc_fct_d;
      res0_q     <= res0_d;
      rem0_q     <= rem0_d;
      res1_q     <= res1_d;
      rem1_q     <= rem1_d;
    end
  end

`ifdef CALC_STATS_EN
  logic [15:0] ops_cnt_q, tmo_cnt_q;

  // Counters step on the same edge that raises valid/timeout, saturating.
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      ops_cnt_q <= '0;
      tmo_cnt_q <= '0;
    end else begin
      if ((|valid_d) && ops_cnt_q != 16'hFFFF) ops_cnt_q <= ops_cnt_q + 16'd1;
      if (timeout_d && tmo_cnt_q != 16'hFFFF)  tmo_cnt_q <= tmo_cnt_q + 16'd1;
    end
  end

  assign ops_cnt_o = ops_cnt_q;
  assign tmo_cnt_o = tmo_cnt_q;
`endif

  assign ack0_o       = ack_q[0];
  assign ack1_o       = ack_q[1];
  assign valid0_o     = valid_q[0];
  assign valid1_o     = valid_q[1];
  assign res0_o       = res0_q;
  assign rem0_o       = rem0_q;
  assign res1_o       = res1_q;
  assign rem1_o       = rem1_q;
  assign calc_start_o = start_q;
  assign calc_a_o     = calc_a_q;
  assign calc_b_o     = calc_b_q;
  assign calc_fct_o   = calc_fct_q;
  assign busy_o       = busy_q;
  assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_calc_arbiter.sv
// Randomized bench for calc_arbiter: a transaction-level model predicts grant
// order, result values and pulse timing; define CALC_STATS_EN to check counters.
module tb_calc_arbiter;

  localparam int W  = 8;
  localparam int TO = 64;

  logic           clock_i = 1'b0;
  logic           reset_i = 1'b0;
  logic           req0_i = 1'b0, req1_i = 1'b0;
  logic [W-1:0]   a0_i = '0, b0_i = '0, a1_i = '0, b1_i = '0;
  logic [1:0]     fct0_i = '0, fct1_i = '0;
  logic           ack0_o, ack1_o, valid0_o, valid1_o;
  logic [2*W-1:0] res0_o, rem0_o, res1_o, rem1_o;
  logic           calc_start_o;
  logic [W-1:0]   calc_a_o, calc_b_o;
  logic [1:0]     calc_fct_o;
  logic [2*W-1:0] calc_res_i = '0, calc_rem_i = '0;
  logic           calc_done_i = 1'b0;
  logic           busy_o, timeout_o;
`ifdef CALC_STATS_EN
  logic [15:0]    ops_cnt_o, tmo_cnt_o;
`endif

  calc_arbiter #(.width(W), .TIMEOUT(TO)) dut (
    .clock_i(clock_i), .reset_i(reset_i),
    .req0_i(req0_i), .a0_i(a0_i), .b0_i(b0_i), .fct0_i(fct0_i),
    .ack0_o(ack0_o), .res0_o(res0_o), .rem0_o(rem0_o), .valid0_o(valid0_o),
    .req1_i(req1_i), .a1_i(a1_i), .b1_i(b1_i), .fct1_i(fct1_i),
    .ack1_o(ack1_o), .res1_o(res1_o), .rem1_o(rem1_o), .valid1_o(valid1_o),
    .calc_start_o(calc_start_o), .calc_a_o(calc_a_o), .calc_b_o(calc_b_o),
    .calc_fct_o(calc_fct_o), .calc_res_i(calc_res_i), .calc_rem_i(calc_rem_i),
    .calc_done_i(calc_done_i), .busy_o(busy_o),
`ifdef CALC_STATS_EN
    .ops_cnt_o(ops_cnt_o), .tmo_cnt_o(tmo_cnt_o),
`endif
    .timeout_o(timeout_o)
  );

  always #5 clock_i = ~clock_i;

  int total = 0;
  int bad   = 0;

  // Reference model: pending requests, client operands, last delivered results.
  bit             reqv [2];
  logic [W-1:0]   opa  [2];
  logic [W-1:0]   opb  [2];
  logic [1:0]     opf  [2];
  logic [2*W-1:0] exp_res [2];
  logic [2*W-1:0] exp_rem [2];
  int             last_served;
  int             obs_gnt;
  int             n_ops, n_tmo;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  task automatic drive();
    req0_i = reqv[0]; a0_i = opa[0]; b0_i = opb[0]; fct0_i = opf[0];
    req1_i = reqv[1]; a1_i = opa[1]; b1_i = opb[1]; fct1_i = opf[1];
  endtask

  task automatic raise(input int c, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [1:0] f);
    reqv[c] = 1'b1; opa[c] = a; opb[c] = b; opf[c] = f;
    drive();
  endtask

  task automatic raise_rand(input int c);
    raise(c, W'($urandom), W'($urandom), 2'($urandom));
  endtask

  // Behavioural calculator: 0 add, 1 subtract, 2 multiply, 3 divide.
  task automatic calc(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] f,
                      output logic [2*W-1:0] r, output logic [2*W-1:0] m);
    int unsigned ua, ub;
    ua = a; ub = b;
    m = '0;
    case (f)
      2'd0: r = 16'(ua + ub);
      2'd1: r = 16'(ua - ub);
      2'd2: r = 16'(ua * ub);
      default: begin
        r = (ub == 0) ? '0 : 16'(ua / ub);
        m = (ub == 0) ? '0 : 16'(ua % ub);
      end
    endcase
  endtask

  task automatic model_reset();
    last_served = 1;
    exp_res[0] = '0; exp_res[1] = '0;
    exp_rem[0] = '0; exp_rem[1] = '0;
    n_ops = 0; n_tmo = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"},   {ack1_o, ack0_o}, 0);
    check({tag, "_valid"}, {valid1_o, valid0_o}, 0);
    check({tag, "_start"}, calc_start_o, 0);
    check({tag, "_busy"},  busy_o, 0);
    check({tag, "_tmo"},   timeout_o, 0);
    check({tag, "_res0"},  res0_o, 0);
    check({tag, "_rem0"},  rem0_o, 0);
    check({tag, "_res1"},  res1_o, 0);
    check({tag, "_rem1"},  rem1_o, 0);
    check({tag, "_ca"},    {calc_fct_o, calc_b_o, calc_a_o}, 0);
`ifdef CALC_STATS_EN
    check({tag, "_stats"}, {ops_cnt_o, tmo_cnt_o}, 0);
`endif
  endtask

  task automatic do_reset();
    reset_i = 1'b0;
    step();
    check_all_zero("reset");
    reset_i = 1'b1;
    model_reset();
  endtask

  // One operation from the current request set. lat >= 0: done rises in WAIT
  // cycle lat and stays up hold more cycles; lat = -1: never done (timeout);
  // lat = -2: reset pulse in WAIT cycle 2.
  task automatic do_op(input int lat, input int hold);
    int g;
    bit hit;
    logic [2*W-1:0] r, m;
    g = (reqv[0] && reqv[1]) ? 1 - last_served : (reqv[1] ? 1 : 0);
    last_served = g;
    calc(opa[g], opb[g], opf[g], r, m);

    step();
    obs_gnt = ack1_o ? 1 : 0;
    check("ack", {ack1_o, ack0_o}, (g == 1) ? 2'b10 : 2'b01);
    check("start", calc_start_o, 1);
    check("calc_ops", {calc_fct_o, calc_b_o, calc_a_o}, {opf[g], opb[g], opa[g]});
    check("busy_start", busy_o, 1);
    reqv[g] = 1'b0;
    drive();

    step();
    check("ack_drop", {ack1_o, ack0_o, calc_start_o}, 0);

    for (int i = 0; i < TO; i++) begin
      calc_done_i = (i == lat);
      calc_res_i  = r;
      calc_rem_i  = m;
      if (lat == -2 && i == 2) begin
        reset_i = 1'b0;
        step();
        check_all_zero("rst_mid");
        reset_i = 1'b1;
        model_reset();
        return;
      end
      step();
      hit = (i == lat) || (lat == -1 && i == TO - 1);
      if (hit) begin
        exp_res[g] = (lat >= 0) ? r : '0;
        exp_rem[g] = (lat >= 0) ? m : '0;
        n_ops++;
        if (lat < 0) n_tmo++;
      end
      check("valid", {valid1_o, valid0_o}, hit ? ((g == 1) ? 2'b10 : 2'b01) : 2'b00);
      check("timeout", timeout_o, (hit && lat < 0) ? 1 : 0);
      if (hit) begin
        check("res0", res0_o, exp_res[0]);
        check("rem0", rem0_o, exp_rem[0]);
        check("res1", res1_o, exp_res[1]);
        check("rem1", rem1_o, exp_rem[1]);
        break;
      end
    end

    for (int h = 0; h < hold; h++) begin
      step();
      check("release_hold", {busy_o, ack1_o, ack0_o, valid1_o, valid0_o}, 5'b10000);
    end
    calc_done_i = 1'b0;
    step();
    check("idle", {busy_o, ack1_o, ack0_o, valid1_o, valid0_o, timeout_o}, 0);
  endtask

  initial begin
    for (int c = 0; c < 2; c++) begin
      reqv[c] = 1'b0; opa[c] = '0; opb[c] = '0; opf[c] = '0;
    end
    model_reset();
    drive();
    step();
    do_reset();

    // Single op, immediate done: 3*7 = 21; client 1 keeps zeros.
    raise(0, 8'h03, 8'h07, 2'b10);
    do_op(0, 0);
    check("t1_res0", res0_o, 16'd21);

    // Tie from reset alternates 0,1,0,1.
    do_reset();
    raise_rand(0);
    raise_rand(1);
    for (int k = 0; k < 4; k++) begin
      do_op(1, 0);
      check("rr_order", obs_gnt, k % 2);
      raise_rand(last_served);
    end
    reqv[0] = 1'b0; reqv[1] = 1'b0;
    drive();
    step();

    // Timeout with no done at all.
    raise_rand(1);
    do_op(-1, 0);

    // Level done held 5 cycles while the other client waits.
    raise_rand(0);
    raise_rand(1);
    do_op(1, 4);
    do_op(0, 0);

    // Reset during WAIT, then a tie goes to client 0.
    raise_rand(0);
    do_op(-2, 0);
    raise_rand(0);
    raise_rand(1);
    do_op(0, 0);
    check("post_rst_gnt", obs_gnt, 0);
    do_op(2, 1);

    // Three completed ops plus one timeout from a clean start.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      raise_rand(k % 2);
      do_op((k == 2) ? -1 : k, 0);
    end
`ifdef CALC_STATS_EN
    check("ops_cnt", ops_cnt_o, 4);
    check("tmo_cnt", tmo_cnt_o, 1);
`endif

    // Random traffic.
    for (int k = 0; k < 40; k++) begin
      int lat;
      for (int c = 0; c < 2; c++)
        if (!reqv[c] && $urandom_range(0, 1) == 1) raise_rand(c);
      if (!reqv[0] && !reqv[1]) raise_rand(int'($urandom_range(0, 1)));
      lat = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 4));
      do_op(lat, (lat < 0) ? 0 : int'($urandom_range(0, 3)));
    end
`ifdef CALC_STATS_EN
    check("ops_cnt_end", ops_cnt_o, 32'(n_ops));
    check("tmo_cnt_end", tmo_cnt_o, 32'(n_tmo));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
